// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Holds the FSM state encoding plus the default memory size and NOP word.
package imem_pkg;

  localparam int unsigned IMEM_BYTES_DEF = 32;
  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR       = 2'd3
  } arb_state_e;

endpackage

// File: rtl/imem_arbiter.sv
// Arbitrates a core fetch port and a loader word-write port onto one
// synchronous word-read / byte-write instruction memory.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEF,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_req,
  input  logic [29:0]                   fetch_addr,
  output logic                          fetch_gnt,
  output logic                          fetch_rvalid,
  output logic [31:0]                   fetch_rdata,
  output logic                          fetch_err,
  input  logic                          load_req,
  input  logic [29:0]                   load_addr,
  input  logic [31:0]                   load_wdata,
  output logic                          load_gnt,
  output logic                          load_done,
  output logic                          load_err,
  output logic                          core_hold,
  output logic                          mem_re,
  output logic [$clog2(IMEM_BYTES)-3:0] mem_raddr,
  input  logic [31:0]                   mem_rdata,
  output logic                          mem_we,
  output logic [$clog2(IMEM_BYTES)-1:0] mem_waddr,
  output logic [7:0]                    mem_wdata
);

  localparam int unsigned BAW    = $clog2(IMEM_BYTES);
  localparam int unsigned WAW    = BAW - 2;
  localparam logic [31:0] NWORDS = 32'(IMEM_BYTES / 4);

  arb_state_e        state, state_nx;
  logic              last_load;
  logic [1:0]        cnt;
  logic [WAW-1:0]    cap_addr;
  logic [31:0]       cap_wdata;
  logic              cap_oor;
  logic              fetch_oor, load_oor;

  assign fetch_oor = {2'b00, fetch_addr} >= NWORDS;
  assign load_oor  = {2'b00, load_addr}  >= NWORDS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_load <= 1'b0;
      cnt       <= 2'd0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_oor   <= 1'b0;
    end else begin
      state <= state_nx;
      if (fetch_gnt) begin
        cap_addr  <= fetch_addr[WAW-1:0];
        cap_oor   <= fetch_oor;
        last_load <= 1'b0;
      end
      if (load_gnt) begin
        cap_addr  <= load_addr[WAW-1:0];
        cap_wdata <= load_wdata;
        cap_oor   <= load_oor;
        last_load <= 1'b1;
      end
      // 2-bit counter wraps back to 0 as the last byte leaves WR
      if (state == WR && !cap_oor)
        cnt <= cnt + 2'd1;
    end
  end

  // Every output is gated by rst so an asynchronous reset silences the ports at once.
  always_comb begin
    state_nx     = state;
    fetch_gnt    = 1'b0;
    fetch_rvalid = 1'b0;
    fetch_rdata  = '0;
    fetch_err    = 1'b0;
    load_gnt     = 1'b0;
    load_done    = 1'b0;
    load_err     = 1'b0;
    mem_re       = 1'b0;
    mem_raddr    = '0;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          // load has priority, except right after a load when the core is waiting
          if (load_req && !(last_load && fetch_req)) begin
            load_gnt = 1'b1;
            state_nx = WR;
          end else if (fetch_req) begin
            fetch_gnt = 1'b1;
            state_nx  = RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          mem_re    = !cap_oor;
          mem_raddr = cap_oor ? '0 : cap_addr;
          state_nx  = RD_WAIT;
        end
        RD_WAIT: begin
          fetch_rvalid = 1'b1;
          fetch_err    = cap_oor;
          fetch_rdata  = cap_oor ? NOP_INSTR : mem_rdata;
          state_nx     = IDLE;
        end
        WR: begin
          if (cap_oor) begin
            load_err = 1'b1;
            state_nx = IDLE;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = {cap_addr, cnt};
            mem_wdata = cap_wdata[{cnt, 3'b000} +: 8];
            if (cnt == 2'd3) begin
              load_done = 1'b1;
              state_nx  = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign core_hold = !rst && (load_req || state == WR);

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized self-checking bench for imem_arbiter with a byte-array memory
// and a word-level reference image of what the memory should hold.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int          IMEM_BYTES = 32;
  localparam int          NW         = IMEM_BYTES / 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk, rst;
  logic        fetch_req, fetch_gnt, fetch_rvalid, fetch_err;
  logic [29:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        load_req, load_gnt, load_done, load_err, core_hold;
  logic [29:0] load_addr;
  logic [31:0] load_wdata;
  logic        mem_re, mem_we;
  logic [2:0]  mem_raddr;
  logic [4:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata = '0;

  imem_arbiter #(.IMEM_BYTES(IMEM_BYTES), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_gnt(load_gnt), .load_done(load_done), .load_err(load_err),
    .core_hold(core_hold),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external synchronous block RAM
  logic [7:0] ram [IMEM_BYTES] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= {ram[{mem_raddr, 2'd3}], ram[{mem_raddr, 2'd2}],
                              ram[{mem_raddr, 2'd1}], ram[{mem_raddr, 2'd0}]};
  end

  function automatic logic [31:0] ram_word(input int a);
    return {ram[a*4+3], ram[a*4+2], ram[a*4+1], ram[a*4]};
  endfunction

  int          n_checks = 0, n_fail = 0, excl_bad = 0;
  logic [31:0] model_mem [NW] = '{default: 32'h0};
  bit          last_load_g;

  always @(negedge clk) if (mem_re && mem_we) excl_bad++;

  // observations filled by the driver tasks
  bit          o_ok;
  int          o_wait;
  logic        o_re1, o_rv1, o_rv2, o_err2;
  logic [2:0]  o_raddr1;
  logic [31:0] o_rd2;
  logic [3:0]  o_we, o_done, o_lerr, o_hold;
  logic [4:0]  o_waddr [4];
  logic [7:0]  o_wbyte [4];
  logic [56:0] ov;

  task automatic run_fetch(input logic [29:0] a);
    fetch_req = 1'b1; fetch_addr = a; o_ok = 0; o_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_gnt) begin o_ok = 1; break; end
      o_wait++;
      @(posedge clk); #1;
    end
    if (!o_ok) begin fetch_req = 1'b0; return; end
    @(posedge clk); #1; fetch_req = 1'b0;
    @(negedge clk); o_re1 = mem_re; o_raddr1 = mem_raddr; o_rv1 = fetch_rvalid;
    @(posedge clk); #1;
    @(negedge clk); o_rv2 = fetch_rvalid; o_rd2 = fetch_rdata; o_err2 = fetch_err;
    @(posedge clk); #1;
    last_load_g = 0;
  endtask

  task automatic run_load(input logic [29:0] a, input logic [31:0] d);
    load_req = 1'b1; load_addr = a; load_wdata = d; o_ok = 0; o_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load_gnt) begin o_ok = 1; break; end
      o_wait++;
      @(posedge clk); #1;
    end
    if (!o_ok) begin load_req = 1'b0; return; end
    @(posedge clk); #1; load_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      o_we[k] = mem_we; o_waddr[k] = mem_waddr; o_wbyte[k] = mem_wdata;
      o_done[k] = load_done; o_lerr[k] = load_err; o_hold[k] = core_hold;
      @(posedge clk); #1;
    end
    last_load_g = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b1; load_req = 1'b1;
    fetch_addr = 30'd1; load_addr = 30'd1; load_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ov = {fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, load_gnt, load_done, load_err,
          core_hold, mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata};
    n_checks++; if (ov !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", ov); end
    fetch_req = 1'b0; load_req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    last_load_g = 0;
  endtask

  task automatic test_load();
    logic [31:0] d = 32'h1122_3344;
    run_load(30'd1, d);
    n_checks++; if (o_ok !== 1'b1) begin n_fail++; $display("FAIL load_grant: got %0d want 1", o_ok); end
    n_checks++; if (o_we !== 4'hF) begin n_fail++; $display("FAIL load_we: got %b want 1111", o_we); end
    n_checks++; if (o_done !== 4'b1000) begin n_fail++; $display("FAIL load_done: got %b want 1000", o_done); end
    n_checks++; if (o_hold !== 4'hF) begin n_fail++; $display("FAIL load_hold: got %b want 1111", o_hold); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_waddr[k] !== 5'(4 + k) || o_wbyte[k] !== 8'(d >> (8 * k))) begin
        n_fail++;
        $display("FAIL load_byte%0d: got addr %0d data %h want addr %0d data %h",
                 k, o_waddr[k], o_wbyte[k], 4 + k, 8'(d >> (8 * k)));
      end
    end
    model_mem[1] = d;
    run_fetch(30'd1);
    n_checks++; if (o_rd2 !== 32'h1122_3344 || o_rv2 !== 1'b1) begin n_fail++; $display("FAIL load_readback: got %h rv %0d want 11223344", o_rd2, o_rv2); end
  endtask

  task automatic test_single_fetch();
    run_load(30'd2, 32'hDEAD_BEEF);
    model_mem[2] = 32'hDEAD_BEEF;
    run_fetch(30'd2);
    n_checks++; if (o_ok !== 1'b1 || o_wait !== 0) begin n_fail++; $display("FAIL fetch_gnt_latency: got ok %0d wait %0d want 1/0", o_ok, o_wait); end
    n_checks++; if (o_re1 !== 1'b1 || o_raddr1 !== 3'd2) begin n_fail++; $display("FAIL fetch_issue: got re %0d addr %0d want 1/2", o_re1, o_raddr1); end
    n_checks++; if (o_rv1 !== 1'b0) begin n_fail++; $display("FAIL fetch_early_rvalid: got %0d want 0", o_rv1); end
    n_checks++; if (o_rv2 !== 1'b1 || o_rd2 !== 32'hDEAD_BEEF || o_err2 !== 1'b0) begin n_fail++; $display("FAIL fetch_data: got rv %0d data %h err %0d want 1/deadbeef/0", o_rv2, o_rd2, o_err2); end
  endtask

  task automatic test_out_of_range();
    run_fetch(30'd8);
    n_checks++; if (o_re1 !== 1'b0) begin n_fail++; $display("FAIL oor_fetch_re: got %0d want 0", o_re1); end
    n_checks++; if (o_rv2 !== 1'b1 || o_rd2 !== NOP || o_err2 !== 1'b1) begin n_fail++; $display("FAIL oor_fetch_data: got rv %0d data %h err %0d want 1/%h/1", o_rv2, o_rd2, o_err2, NOP); end
    run_load(30'd8, 32'hCAFE_F00D);
    n_checks++; if (o_we !== 4'h0 || o_done !== 4'h0) begin n_fail++; $display("FAIL oor_load_we: got we %b done %b want 0/0", o_we, o_done); end
    n_checks++; if (o_lerr !== 4'b0001) begin n_fail++; $display("FAIL oor_load_err: got %b want 0001", o_lerr); end
  endtask

  task automatic test_alternation();
    bit   g_kind [6];
    int   g_cyc [6];
    int   ng = 0, cyc = 0, hold_bad = 0;
    bit   first;
    logic [31:0] d = $urandom;
    run_fetch(30'd0);
    first = !last_load_g;
    load_req = 1'b1; fetch_req = 1'b1; load_addr = 30'd3; fetch_addr = 30'd3; load_wdata = d;
    while (ng < 6 && cyc < 100) begin
      @(negedge clk);
      if (!core_hold) hold_bad++;
      if (load_gnt || fetch_gnt) begin g_kind[ng] = load_gnt; g_cyc[ng] = cyc; ng++; end
      cyc++;
      @(posedge clk); #1;
    end
    load_req = 1'b0; fetch_req = 1'b0;
    repeat (6) @(posedge clk); #1;
    n_checks++; if (ng !== 6) begin n_fail++; $display("FAIL alt_count: got %0d want 6", ng); end
    n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL alt_hold: got %0d low cycles want 0", hold_bad); end
    for (int i = 0; i < ng; i++) begin
      n_checks++;
      if (g_kind[i] !== (first ^ i[0])) begin n_fail++; $display("FAIL alt_order%0d: got load=%0d want load=%0d", i, g_kind[i], first ^ i[0]); end
      if (i > 0) begin
        n_checks++;
        if (g_cyc[i] - g_cyc[i-1] !== (g_kind[i-1] ? 5 : 3)) begin
          n_fail++; $display("FAIL alt_gap%0d: got %0d want %0d", i, g_cyc[i] - g_cyc[i-1], g_kind[i-1] ? 5 : 3);
        end
      end
    end
    model_mem[3] = d;
    last_load_g = g_kind[5];
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] d = 32'hAABB_CCDD, old = model_mem[4], expw;
    bit seen_done = 0;
    load_req = 1'b1; load_addr = 30'd4; load_wdata = d;
    @(negedge clk);
    n_checks++; if (load_gnt !== 1'b1) begin n_fail++; $display("FAIL rml_grant: got %0d want 1", load_gnt); end
    @(posedge clk); #1; load_req = 1'b0;
    @(negedge clk); seen_done |= load_done;
    @(posedge clk); #1;
    @(negedge clk); seen_done |= load_done;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    ov = {fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, load_gnt, load_done, load_err,
          core_hold, mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata};
    n_checks++; if (ov !== '0) begin n_fail++; $display("FAIL rml_async_zero: got %h want 0", ov); end
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    last_load_g = 0;
    expw = {old[31:16], d[15:0]};
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rml_done: got %0d want 0", seen_done); end
    n_checks++; if (ram_word(4) !== expw) begin n_fail++; $display("FAIL rml_bytes: got %h want %h", ram_word(4), expw); end
    model_mem[4] = expw;
    run_fetch(30'd4);
    n_checks++; if (o_wait !== 0 || o_rd2 !== expw) begin n_fail++; $display("FAIL rml_idle_fetch: got wait %0d data %h want 0/%h", o_wait, o_rd2, expw); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int          a = $urandom_range(0, NW + 1);
      logic [31:0] d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        run_load(30'(a), d);
        n_checks++;
        if (a < NW) begin
          if (o_we !== 4'hF || o_done !== 4'b1000 || o_lerr !== 4'h0) begin n_fail++; $display("FAIL rnd_load%0d: got we %b done %b err %b want 1111/1000/0000", it, o_we, o_done, o_lerr); end
          for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (o_waddr[k] !== 5'(a * 4 + k) || o_wbyte[k] !== 8'(d >> (8 * k))) begin n_fail++; $display("FAIL rnd_byte%0d_%0d: got %0d/%h want %0d/%h", it, k, o_waddr[k], o_wbyte[k], a * 4 + k, 8'(d >> (8 * k))); end
          end
          model_mem[a] = d;
        end else if (o_we !== 4'h0 || o_done !== 4'h0 || o_lerr !== 4'b0001) begin
          n_fail++; $display("FAIL rnd_oor_load%0d: got we %b done %b err %b want 0000/0000/0001", it, o_we, o_done, o_lerr);
        end
      end else begin
        run_fetch(30'(a));
        n_checks++;
        if (o_rv2 !== 1'b1 || o_rd2 !== ((a < NW) ? model_mem[a % NW] : NOP) || o_err2 !== (a >= NW) || o_re1 !== (a < NW)) begin
          n_fail++; $display("FAIL rnd_fetch%0d: addr %0d got rv %0d data %h err %0d re %0d want 1/%h/%0d/%0d", it, a, o_rv2, o_rd2, o_err2, o_re1,
                             (a < NW) ? model_mem[a % NW] : NOP, a >= NW, a < NW);
        end
      end
    end
    for (int w = 0; w < NW; w++) begin
      n_checks++; if (ram_word(w) !== model_mem[w]) begin n_fail++; $display("FAIL mem_image%0d: got %h want %h", w, ram_word(w), model_mem[w]); end
    end
    n_checks++; if (excl_bad !== 0) begin n_fail++; $display("FAIL re_we_overlap: got %0d cycles want 0", excl_bad); end
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; load_req = 1'b0;
    fetch_addr = '0; load_addr = '0; load_wdata = '0;
    test_reset();
    test_load();
    test_single_fetch();
    test_out_of_range();
    test_alternation();
    test_reset_mid_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
